// File: rtl/axi4lite_regfile_slave_if.sv
// AXI4-Lite bus bundle for the register-file slave: the master drives requests, the slave drives readies and responses.
interface axi4lite_regfile_slave_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic [ADDRESS_WIDTH-1:0]  AWADDR;
    logic [2:0]                AWPROT;
    logic                      AWVALID;
    logic                      AWREADY;
    logic [DATA_WIDTH-1:0]     WDATA;
    logic [DATA_WIDTH/8-1:0]   WSTRB;
    logic                      WVALID;
    logic                      WREADY;
    logic [1:0]                BRESP;
    logic                      BVALID;
    logic                      BREADY;
    logic [ADDRESS_WIDTH-1:0]  ARADDR;
    logic [2:0]                ARPROT;
    logic                      ARVALID;
    logic                      ARREADY;
    logic [DATA_WIDTH-1:0]     RDATA;
    logic [1:0]                RRESP;
    logic                      RVALID;
    logic                      RREADY;

    // A beat transfers on a rising edge where VALID and READY are both high; VALID never waits on READY.
    modport master (
        output AWADDR, AWPROT, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input BRESP, BVALID, output BREADY,
        output ARADDR, ARPROT, ARVALID, input ARREADY,
        input RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input AWADDR, AWPROT, AWVALID, output AWREADY,
        input WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input ARADDR, ARPROT, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/axi4lite_regfile_slave.sv
// AXI4-Lite register file: register 0 is a read-only ID, the rest are byte-strobed RW words.
module axi4lite_regfile_slave #(
    parameter int          ADDRESS_WIDTH = 32,
    parameter int          DATA_WIDTH    = 32,
    parameter int          NUM_REGS      = 16,
    // The documented ID 32'hA4L1_0001 is not legal hex; the L is read as 1.
    parameter logic [31:0] ID_VALUE      = 32'hA411_0001
) (
    input logic                     ACLK,
    input logic                     ARESETn,
    axi4lite_regfile_slave_if.slave bus
);
    localparam int ADDR_LSB = (DATA_WIDTH == 64) ? 3 : 2;
    localparam int IDX_W    = ADDRESS_WIDTH - ADDR_LSB;
    localparam int REG_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam logic [IDX_W-1:0]      NUM_REGS_IDX = IDX_W'(NUM_REGS);
    localparam logic [DATA_WIDTH-1:0] ID_EXT       = DATA_WIDTH'(ID_VALUE);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                     r_aw_held, r_w_held, r_bvalid, r_rvalid;
    logic [ADDRESS_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0]    r_wdata, r_rdata;
    logic [STRB_W-1:0]        r_wstrb;
    logic [1:0]               r_bresp, r_rresp;
    logic [DATA_WIDTH-1:0]    r_regs [NUM_REGS];

    logic                     w_awready, w_wready, w_arready;
    logic                     w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [ADDRESS_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0]    w_wdata;
    logic [STRB_W-1:0]        w_wstrb;
    logic [IDX_W-1:0]         w_widx, w_ridx;
    logic [REG_W-1:0]         w_wreg, w_rreg;
    logic                     w_wr_ok, w_rd_inrange;
    logic                     w_unused_bits;

    // Readies are gated by reset so they read 0 while ARESETn is low.
    assign w_awready = ARESETn && !r_aw_held && !r_bvalid;
    assign w_wready  = ARESETn && !r_w_held && !r_bvalid;
    assign w_arready = ARESETn && !r_rvalid;
    assign w_aw_hs   = bus.AWVALID && w_awready;
    assign w_w_hs    = bus.WVALID && w_wready;
    assign w_ar_hs   = bus.ARVALID && w_arready;
    assign w_commit  = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

    assign w_waddr = r_aw_held ? r_awaddr : bus.AWADDR;
    assign w_wdata = r_w_held ? r_wdata : bus.WDATA;
    assign w_wstrb = r_w_held ? r_wstrb : bus.WSTRB;
    assign w_widx  = w_waddr[ADDRESS_WIDTH-1:ADDR_LSB];
    assign w_wreg  = w_widx[REG_W-1:0];
    assign w_wr_ok = (w_widx < NUM_REGS_IDX) && (w_widx != '0);

    assign w_ridx       = bus.ARADDR[ADDRESS_WIDTH-1:ADDR_LSB];
    assign w_rreg       = w_ridx[REG_W-1:0];
    assign w_rd_inrange = (w_ridx < NUM_REGS_IDX);

    assign w_unused_bits = ^{bus.AWPROT, bus.ARPROT, w_waddr[ADDR_LSB-1:0], bus.ARADDR[ADDR_LSB-1:0]};

    assign bus.AWREADY = w_awready;
    assign bus.WREADY  = w_wready;
    assign bus.ARREADY = w_arready;
    assign bus.BVALID  = r_bvalid;
    assign bus.BRESP   = r_bresp;
    assign bus.RVALID  = r_rvalid;
    assign bus.RDATA   = r_rdata;
    assign bus.RRESP   = r_rresp;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_awaddr  <= bus.AWADDR;
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= bus.WDATA;
                    r_wstrb  <= bus.WSTRB;
                end
                if (r_bvalid && bus.BREADY) r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_commit && w_wr_ok) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_wstrb[b]) r_regs[w_wreg][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    // Sampling r_regs here gives the pre-write value when a write commits on the same edge.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            if (!w_rd_inrange) begin
                r_rdata <= '0;
                r_rresp <= RESP_SLVERR;
            end else if (w_ridx == '0) begin
                r_rdata <= ID_EXT;
                r_rresp <= RESP_OKAY;
            end else begin
                r_rdata <= r_regs[w_rreg];
                r_rresp <= RESP_OKAY;
            end
        end else if (r_rvalid && bus.RREADY) begin
            r_rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axi4lite_regfile_slave.sv
// Bench for axi4lite_regfile_slave: directed scenarios plus random traffic against an array-based model.
module tb_axi4lite_regfile_slave;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 16;
    localparam logic [31:0] ID = 32'hA411_0001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi4lite_regfile_slave_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4lite_regfile_slave #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .ID_VALUE(ID)
    ) dut (
        .ACLK(clk), .ARESETn(rst_n), .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int stall_pct = 0;
    bit hold_b = 1'b0;
    bit hold_r = 1'b0;

    logic [DW-1:0] model [NR];
    logic [1:0]    exp_b_q [$];
    logic [DW+1:0] exp_r_q [$];
    logic [1:0]    last_bresp, last_rresp;
    logic [DW-1:0] last_rdata;
    logic [DW+1:0] e, e_r;
    logic [AW-1:0] a;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_chk(input string name, input bit ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: event not seen within bound, required within bound at %0t", name, $time);
        end
    endtask

    // Model: word index = addr/4, reg 0 is the ID, index >= NR is out of range.
    function automatic logic [1:0] model_write(input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [3:0] s);
        int unsigned idx;
        idx = ad >> 2;
        if (idx >= NR || idx == 0) return 2'b10;
        for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
        return 2'b00;
    endfunction

    function automatic logic [DW+1:0] model_read(input logic [AW-1:0] ad);
        int unsigned idx;
        idx = ad >> 2;
        if (idx >= NR) return {2'b10, {DW{1'b0}}};
        if (idx == 0) return {2'b00, ID};
        return {2'b00, model[idx]};
    endfunction

    initial begin
        bus.BREADY = 1'b1;
        bus.RREADY = 1'b1;
        forever begin
            @(posedge clk); #2;
            bus.BREADY = !hold_b && (int'($urandom_range(0, 99)) >= stall_pct);
            bus.RREADY = !hold_r && (int'($urandom_range(0, 99)) >= stall_pct);
        end
    end

    // Compare process: reset values, responses against the queues, stability while stalled.
    bit prev_bv = 0, prev_bhs = 0, prev_rv = 0, prev_rhs = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outputs", {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID,
                                    bus.BRESP, bus.RRESP, bus.RDATA}, 64'd0);
            prev_bv = 0; prev_bhs = 0; prev_rv = 0; prev_rhs = 0;
        end else begin
            if (bus.BVALID) begin
                if (!prev_bv || prev_bhs) begin
                    last_bresp = bus.BRESP;
                    if (exp_b_q.size() == 0) bound_chk("b_unexpected", 1'b0);
                    else check("bresp", bus.BRESP, exp_b_q.pop_front());
                end else check("bresp_stable", bus.BRESP, last_bresp);
            end
            if (bus.RVALID) begin
                if (!prev_rv || prev_rhs) begin
                    last_rdata = bus.RDATA;
                    last_rresp = bus.RRESP;
                    if (exp_r_q.size() == 0) bound_chk("r_unexpected", 1'b0);
                    else begin
                        e_r = exp_r_q.pop_front();
                        check("rdata", bus.RDATA, e_r[DW-1:0]);
                        check("rresp", bus.RRESP, e_r[DW+1:DW]);
                    end
                end else begin
                    check("rdata_stable", bus.RDATA, last_rdata);
                    check("rresp_stable", bus.RRESP, last_rresp);
                end
            end
            prev_bv = bus.BVALID; prev_bhs = bus.BVALID && bus.BREADY;
            prev_rv = bus.RVALID; prev_rhs = bus.RVALID && bus.RREADY;
        end
    end

    // Driver tasks: entered just after a rising edge, return just after a rising edge.
    task automatic drive_aw(input logic [AW-1:0] ad, input int dly);
        bit done;
        if (dly > 0) begin repeat (dly) @(posedge clk); #1; end
        bus.AWADDR = ad; bus.AWVALID = 1'b1; done = 0;
        for (int i = 0; i < 100 && !done; i++) begin @(negedge clk); done = bus.AWREADY; end
        @(posedge clk); #1;
        bus.AWVALID = 1'b0;
        bound_chk("aw_handshake", done);
    endtask

    task automatic drive_w(input logic [DW-1:0] d, input logic [3:0] s, input int dly);
        bit done;
        if (dly > 0) begin repeat (dly) @(posedge clk); #1; end
        bus.WDATA = d; bus.WSTRB = s; bus.WVALID = 1'b1; done = 0;
        for (int i = 0; i < 100 && !done; i++) begin @(negedge clk); done = bus.WREADY; end
        @(posedge clk); #1;
        bus.WVALID = 1'b0;
        bound_chk("w_handshake", done);
    endtask

    task automatic wait_b_done();
        bit done;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin @(negedge clk); done = bus.BVALID && bus.BREADY; end
        @(posedge clk); #1;
        bound_chk("b_handshake", done);
    endtask

    task automatic wait_r_done();
        bit done;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin @(negedge clk); done = bus.RVALID && bus.RREADY; end
        @(posedge clk); #1;
        bound_chk("r_handshake", done);
    endtask

    task automatic do_write(input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly);
        exp_b_q.push_back(model_write(ad, d, s));
        fork
            drive_aw(ad, aw_dly);
            drive_w(d, s, w_dly);
        join
        wait_b_done();
    endtask

    task automatic do_read_exp(input logic [AW-1:0] ad, input int dly, input logic [DW+1:0] ex);
        bit done;
        exp_r_q.push_back(ex);
        if (dly > 0) begin repeat (dly) @(posedge clk); #1; end
        bus.ARADDR = ad; bus.ARVALID = 1'b1; done = 0;
        for (int i = 0; i < 100 && !done; i++) begin @(negedge clk); done = bus.ARREADY; end
        @(posedge clk); #1;
        bus.ARVALID = 1'b0;
        bound_chk("ar_handshake", done);
        wait_r_done();
    endtask

    task automatic do_read(input logic [AW-1:0] ad, input int dly);
        do_read_exp(ad, dly, model_read(ad));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NR; i++) model[i] = '0;
        bus.AWADDR = '0; bus.AWPROT = 3'd0; bus.AWVALID = 1'b0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
        bus.ARADDR = '0; bus.ARPROT = 3'd0; bus.ARVALID = 1'b0;

        // Reset, then release mid-cycle; readies must be up before the first edge.
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check("ready_after_reset", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
        @(posedge clk); #1;

        // AW and W in the same cycle.
        exp_b_q.push_back(model_write(32'h8, 32'hDEAD_BEEF, 4'hF));
        bus.AWADDR = 32'h8; bus.AWVALID = 1'b1;
        bus.WDATA = 32'hDEAD_BEEF; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        @(negedge clk);
        check("req018_ready", {bus.AWREADY, bus.WREADY}, 2'b11);
        @(posedge clk); #1;
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        @(negedge clk);
        check("req018_bvalid_latency", bus.BVALID, 1'b1);
        check("req018_bresp", bus.BRESP, 2'b00);
        @(posedge clk); #1;
        do_read(32'h8, 0);
        check("req018_rdata", last_rdata, 32'hDEAD_BEEF);
        check("req018_rresp", last_rresp, 2'b00);

        // W three cycles ahead of AW.
        exp_b_q.push_back(model_write(32'h4, 32'hCAFE_F00D, 4'hF));
        bus.WDATA = 32'hCAFE_F00D; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        @(negedge clk);
        check("req019_wready_first", bus.WREADY, 1'b1);
        @(posedge clk); #1;
        bus.WVALID = 1'b0;
        @(negedge clk);
        check("req019_wready_held_low", bus.WREADY, 1'b0);
        check("req019_no_early_b", bus.BVALID, 1'b0);
        repeat (2) @(posedge clk); #1;
        bus.AWADDR = 32'h4; bus.AWVALID = 1'b1;
        @(negedge clk);
        check("req019_awready", bus.AWREADY, 1'b1);
        @(posedge clk); #1;
        bus.AWVALID = 1'b0;
        @(negedge clk);
        check("req019_bvalid_after_aw", bus.BVALID, 1'b1);
        @(posedge clk); #1;
        do_read(32'h4, 0);
        check("req019_reg1", last_rdata, 32'hCAFE_F00D);

        // Byte strobes.
        do_write(32'h8, 32'h1122_3344, 4'hF, 0, 0);
        do_write(32'h8, 32'hAABB_CCDD, 4'h5, 0, 0);
        do_read(32'h8, 0);
        check("req020_strobe_merge", last_rdata, 32'h11BB_33DD);
        do_write(32'h8, 32'hFFFF_FFFF, 4'h0, 0, 0);
        check("strb_zero_okay", last_bresp, 2'b00);
        do_read(32'h8, 0);
        check("strb_zero_nochange", last_rdata, 32'h11BB_33DD);

        // ID register and out-of-range accesses.
        do_write(32'h0, 32'hFFFF_FFFF, 4'hF, 0, 0);
        check("req021_wr_reg0_slverr", last_bresp, 2'b10);
        do_read(32'h2, 0);
        check("req021_id", last_rdata, ID);
        check("req021_id_okay", last_rresp, 2'b00);
        do_write(NR * 4, 32'h1234_5678, 4'hF, 0, 0);
        check("req021_wr_oob_slverr", last_bresp, 2'b10);
        do_read(NR * 4 + 3, 0);
        check("req021_rd_oob_data", last_rdata, 32'h0);
        check("req021_rd_oob_resp", last_rresp, 2'b10);

        // Read and write to the same register on one edge.
        do_write(32'h1C, 32'h0BAD_F00D, 4'hF, 0, 0);
        e = model_read(32'h1C);
        fork
            do_read_exp(32'h1C, 0, e);
            do_write(32'h1C, 32'h1234_5678, 4'hF, 0, 0);
        join
        check("req014_pre_write", last_rdata, 32'h0BAD_F00D);
        do_read(32'h1C, 0);
        check("req014_post_write", last_rdata, 32'h1234_5678);

        // Responses stalled for ten cycles.
        hold_b = 1'b1; hold_r = 1'b1;
        @(posedge clk); #3;
        fork
            do_write(32'hC, 32'h5A5A_A5A5, 4'hF, 0, 0);
            do_read(32'h10, 0);
            begin
                int waited;
                waited = 0;
                while (!(bus.BVALID && bus.RVALID) && waited < 50) begin @(negedge clk); waited++; end
                bound_chk("req022_valids", bus.BVALID && bus.RVALID);
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    check("req022_valids_held", {bus.BVALID, bus.RVALID}, 2'b11);
                    check("req022_readies_low", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b000);
                end
                hold_b = 1'b0; hold_r = 1'b0;
            end
        join

        // Reset with AW held and a read response pending.
        hold_r = 1'b1;
        @(posedge clk); #3;
        exp_r_q.push_back(model_read(32'h14));
        bus.ARADDR = 32'h14; bus.ARVALID = 1'b1;
        bus.AWADDR = 32'h14; bus.AWVALID = 1'b1;
        @(posedge clk); #1;
        bus.ARVALID = 1'b0; bus.AWVALID = 1'b0;
        @(negedge clk);
        check("req023_rvalid_pending", bus.RVALID, 1'b1);
        check("req023_aw_held", bus.AWREADY, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("req023_async_clear", {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID,
                                        bus.BRESP, bus.RRESP, bus.RDATA}, 64'd0);
        for (int i = 0; i < NR; i++) model[i] = '0;
        exp_b_q.delete(); exp_r_q.delete();
        hold_r = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("req023_ready_after", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
        @(posedge clk); #1;
        do_write(32'h18, 32'h0000_0077, 4'hF, 3, 0);
        do_read(32'h14, 0);
        check("req023_no_stale_aw", last_rdata, 32'h0);
        do_read(32'h18, 0);
        check("req023_new_write", last_rdata, 32'h0000_0077);

        // Random traffic with response back-pressure.
        stall_pct = 30;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = ($urandom_range(0, NR + 1) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_read(a, $urandom_range(0, 2));
        end

        repeat (5) @(negedge clk);
        check("b_queue_drained", exp_b_q.size(), 0);
        check("r_queue_drained", exp_r_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
